// File: rtl/lbus_pkg.sv
// Shared local-bus constants, default FIFO sizing and the status-flag bit indices.
package lbus_pkg;

  localparam int unsigned LBUS_DW         = 8;
  localparam int unsigned LBUS_DEPTH_LOG2 = 4;
  localparam int unsigned LBUS_AFUL_TH    = 2;
  localparam int unsigned LBUS_AEMP_TH    = 2;
  localparam int unsigned LBUS_NFLAGS     = 4;

  typedef enum logic [1:0] {
    FLG_FUL  = 2'd0,
    FLG_AFUL = 2'd1,
    FLG_EMP  = 2'd2,
    FLG_AEMP = 2'd3
  } lbus_flag_e;

endpackage

// File: rtl/lbus_fifo_ram.sv
// DEPTH x LBUS_DW simple dual-port array: synchronous write, registered read with enable.
module lbus_fifo_ram
  import lbus_pkg::*;
#(
  parameter int unsigned AW = LBUS_DEPTH_LOG2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [LBUS_DW-1:0] wdata,
  input  logic               re,
  input  logic [AW-1:0]      raddr,
  output logic [LBUS_DW-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [LBUS_DW-1:0] mem [DEPTH];

  // Storage is deliberately left unreset so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/lbus_byte_fifo.sv
// Synchronous byte FIFO between the local-bus pins and the host interface.
// Optional sticky overflow/underflow outputs enabled by LBUS_FIFO_ERR_STICKY_EN.
module lbus_byte_fifo
  import lbus_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = LBUS_DEPTH_LOG2,
  parameter int unsigned AFUL_TH    = LBUS_AFUL_TH,
  parameter int unsigned AEMP_TH    = LBUS_AEMP_TH
) (
  input  logic                CLK,
  input  logic                RSTn,
  input  logic                WE,
  input  logic [LBUS_DW-1:0]  DIN,
  output logic                FUL,
  output logic                AFUL,
  input  logic                RE,
  output logic [LBUS_DW-1:0]  DOUT,
  output logic                EMP,
  output logic                AEMP,
  output logic [DEPTH_LOG2:0] COUNT
`ifdef LBUS_FIFO_ERR_STICKY_EN
  ,
  output logic                OVF,
  output logic                UDF
`endif
);

  localparam int unsigned AW    = DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [AW-1:0]          wptr;
  logic [AW-1:0]          rptr;
  logic [AW-1:0]          wptr_next;
  logic [AW-1:0]          rptr_next;
  logic [CW-1:0]          count_next;
  logic [LBUS_NFLAGS-1:0] flags;
  logic [LBUS_NFLAGS-1:0] flags_next;
  logic                   wr_acc;
  logic                   rd_acc;

  // Accesses are gated by the registered flags; reset also blocks any array write.
  always_comb begin
    wr_acc     = RSTn & WE & ~flags[FLG_FUL];
    rd_acc     = RSTn & RE & ~flags[FLG_EMP];
    wptr_next  = wptr;
    rptr_next  = rptr;
    count_next = COUNT + CW'(wr_acc) - CW'(rd_acc);
    flags_next = '0;
    if (wr_acc) begin
      wptr_next = wptr + AW'(1);
    end
    if (rd_acc) begin
      rptr_next = rptr + AW'(1);
    end
    flags_next[FLG_FUL]  = (count_next == CW'(DEPTH));
    flags_next[FLG_AFUL] = (count_next >= CW'(DEPTH - AFUL_TH));
    flags_next[FLG_EMP]  = (count_next == CW'(0));
    flags_next[FLG_AEMP] = (count_next <= CW'(AEMP_TH));
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      wptr  <= '0;
      rptr  <= '0;
      COUNT <= '0;
      flags <= LBUS_NFLAGS'((1 << FLG_EMP) | (1 << FLG_AEMP));
    end else begin
      wptr  <= wptr_next;
      rptr  <= rptr_next;
      COUNT <= count_next;
      flags <= flags_next;
    end
  end

  assign FUL  = flags[FLG_FUL];
  assign AFUL = flags[FLG_AFUL];
  assign EMP  = flags[FLG_EMP];
  assign AEMP = flags[FLG_AEMP];

  lbus_fifo_ram #(
    .AW (AW)
  ) u_ram (
    .clk   (CLK),
    .rst_n (RSTn),
    .we    (wr_acc),
    .waddr (wptr),
    .wdata (DIN),
    .re    (rd_acc),
    .raddr (rptr),
    .rdata (DOUT)
  );

`ifdef LBUS_FIFO_ERR_STICKY_EN
  // Sticky until reset; fed to spare LEDs.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      OVF <= 1'b0;
      UDF <= 1'b0;
    end else begin
      if (WE && flags[FLG_FUL]) begin
        OVF <= 1'b1;
      end
      if (RE && flags[FLG_EMP]) begin
        UDF <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lbus_byte_fifo.sv
// Self-checking bench for lbus_byte_fifo: vector table, directed corner sequences, random vs queue model.
module tb_lbus_byte_fifo;

  localparam int unsigned DL    = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AFT   = 2;
  localparam int unsigned AET   = 2;

  logic       clk = 1'b0;
  logic       rstn;
  logic       we;
  logic       re;
  logic [7:0] din;
  logic       ful, aful, emp, aemp;
  logic [7:0] dout;
  logic [DL:0] count;
`ifdef LBUS_FIFO_ERR_STICKY_EN
  logic       ovf, udf;
`endif

  lbus_byte_fifo #(.DEPTH_LOG2(DL), .AFUL_TH(AFT), .AEMP_TH(AET)) dut (
    .CLK(clk), .RSTn(rstn), .WE(we), .DIN(din), .FUL(ful), .AFUL(aful),
    .RE(re), .DOUT(dout), .EMP(emp), .AEMP(aemp), .COUNT(count)
`ifdef LBUS_FIFO_ERR_STICKY_EN
    , .OVF(ovf), .UDF(udf)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: a byte queue plus the last value read out.
  logic [7:0] q[$];
  logic [7:0] m_dout;
  bit         m_ovf, m_udf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_flags();
    int n = q.size();
    return {n == DEPTH, n >= DEPTH - AFT, n == 0, n <= AET};
  endfunction

  task automatic step(input bit r, input bit w, input logic [7:0] d, input bit rd);
    rstn = r; we = w; din = d; re = rd;
    @(posedge clk);
    #1;
    if (!r) begin
      q.delete();
      m_dout = 8'h00;
      m_ovf = 0;
      m_udf = 0;
    end else begin
      bit wa = w && (q.size() < DEPTH);
      bit ra = rd && (q.size() > 0);
      if (w && q.size() == DEPTH) m_ovf = 1;
      if (rd && q.size() == 0) m_udf = 1;
      if (ra) m_dout = q.pop_front();
      if (wa) q.push_back(d);
    end
    chk("count", 32'(count), 32'(q.size()));
    chk("flags", {28'd0, ful, aful, emp, aemp}, {28'd0, model_flags()});
    chk("dout", 32'(dout), 32'(m_dout));
`ifdef LBUS_FIFO_ERR_STICKY_EN
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("udf", 32'(udf), 32'(m_udf));
`endif
  endtask

  typedef struct {
    bit         rstn;
    bit         we;
    bit         re;
    logic [7:0] din;
    int         cnt;
    logic [7:0] dout;
    logic [3:0] flg;  // {FUL, AFUL, EMP, AEMP}
  } vec_t;

  vec_t tbl[13];

  initial begin
    rstn = 1'b0; we = 1'b0; re = 1'b0; din = 8'h00;
    m_dout = 8'h00;

    // Reset with write held, empty simultaneous access, short in-order traffic.
    tbl[0]  = '{0, 1, 0, 8'hA5, 0, 8'h00, 4'b0011};
    tbl[1]  = '{0, 1, 0, 8'hA5, 0, 8'h00, 4'b0011};
    tbl[2]  = '{0, 1, 0, 8'hA5, 0, 8'h00, 4'b0011};
    tbl[3]  = '{1, 1, 1, 8'h3C, 1, 8'h00, 4'b0001};
    tbl[4]  = '{1, 0, 1, 8'h00, 0, 8'h3C, 4'b0011};
    tbl[5]  = '{1, 1, 0, 8'h11, 1, 8'h3C, 4'b0001};
    tbl[6]  = '{1, 1, 0, 8'h22, 2, 8'h3C, 4'b0001};
    tbl[7]  = '{1, 1, 0, 8'h33, 3, 8'h3C, 4'b0000};
    tbl[8]  = '{1, 1, 1, 8'h44, 3, 8'h11, 4'b0000};
    tbl[9]  = '{1, 0, 1, 8'h00, 2, 8'h22, 4'b0001};
    tbl[10] = '{1, 0, 1, 8'h00, 1, 8'h33, 4'b0001};
    tbl[11] = '{1, 0, 1, 8'h00, 0, 8'h44, 4'b0011};
    tbl[12] = '{1, 0, 1, 8'h00, 0, 8'h44, 4'b0011};
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].rstn, tbl[i].we, tbl[i].din, tbl[i].re);
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_dout", i), 32'(dout), 32'(tbl[i].dout));
      chk($sformatf("tbl%0d_flags", i), {28'd0, ful, aful, emp, aemp}, {28'd0, tbl[i].flg});
    end

    // Fill and drain with threshold edges.
    step(0, 0, 8'h00, 0);
    for (int i = 0; i < 16; i++) begin
      step(1, 1, 8'(i), 0);
      if (i == 12) chk("aful_after13", 32'(aful), 32'd0);
      if (i == 13) chk("aful_after14", 32'(aful), 32'd1);
      if (i == 14) chk("ful_after15", 32'(ful), 32'd0);
    end
    chk("ful_after16", 32'(ful), 32'd1);
    chk("count_full", 32'(count), 32'd16);
    step(1, 1, 8'hFF, 0);
    chk("count_after_drop", 32'(count), 32'd16);
`ifdef LBUS_FIFO_ERR_STICKY_EN
    chk("ovf_set", 32'(ovf), 32'd1);
`endif
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 8'h00, 1);
      chk("drain_data", 32'(dout), 32'(i));
      if (i == 12) chk("aemp_at3", 32'(aemp), 32'd0);
      if (i == 13) chk("aemp_at2", 32'(aemp), 32'd1);
      if (i == 14) chk("emp_at1", 32'(emp), 32'd0);
    end
    chk("emp_after16", 32'(emp), 32'd1);

    // Wrap-around.
    for (int i = 0; i < 10; i++) step(1, 1, 8'(8'h10 + i), 0);
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 8'h00, 1);
      chk("wrap_a_data", 32'(dout), 32'(8'h10 + i));
    end
    for (int i = 0; i < 12; i++) step(1, 1, 8'(8'h20 + i), 0);
    for (int i = 0; i < 12; i++) begin
      step(1, 0, 8'h00, 1);
      chk("wrap_b_data", 32'(dout), 32'(8'h20 + i));
    end
    chk("wrap_count0", 32'(count), 32'd0);

    // Simultaneous access when full: write dropped.
    for (int i = 0; i < 16; i++) step(1, 1, 8'(8'h40 + i), 0);
    step(1, 1, 8'h77, 1);
    chk("simfull_dout", 32'(dout), 32'h40);
    chk("simfull_count", 32'(count), 32'd15);
    chk("simfull_ful", 32'(ful), 32'd0);
    for (int i = 0; i < 15; i++) begin
      step(1, 0, 8'h00, 1);
      chk("simfull_drain", 32'(dout), 32'(8'h41 + i));
    end

    // Simultaneous access when empty: read dropped.
    step(1, 1, 8'h3C, 1);
    chk("simemp_dout", 32'(dout), 32'h4F);
    chk("simemp_count", 32'(count), 32'd1);
    chk("simemp_emp", 32'(emp), 32'd0);
`ifdef LBUS_FIFO_ERR_STICKY_EN
    chk("udf_set", 32'(udf), 32'd1);
`endif
    step(1, 0, 8'h00, 1);
    chk("simemp_next", 32'(dout), 32'h3C);

    // Reset mid-operation discards queued bytes.
    for (int i = 0; i < 5; i++) step(1, 1, 8'(8'hC0 + i), 0);
    step(0, 0, 8'h00, 0);
    chk("rstmid_count", 32'(count), 32'd0);
    chk("rstmid_emp", 32'(emp), 32'd1);
    step(1, 1, 8'h5A, 0);
    step(1, 0, 8'h00, 1);
    chk("rstmid_data", 32'(dout), 32'h5A);

    // Random traffic with phase-varying bias and rare resets.
    for (int ph = 0; ph < 6; ph++) begin
      int wp = 20 + ph * 12;
      int rp = 80 - ph * 12;
      for (int i = 0; i < 500; i++) begin
        bit r = ($urandom_range(299) != 0);
        bit w = ($urandom_range(99) < wp);
        bit rd = ($urandom_range(99) < rp);
        step(r, w, 8'($urandom), rd);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lbus_byte_fifo.md
Name: lbus_byte_fifo

Overview:
- Synchronous byte FIFO placed between the SAKURA-G local-bus pins and the host interface controller.
- Two instances are used, one per direction:
  - Host→device: write side on lbus_wd/lbus_we; read side drained by the host interface.
  - Device→host: write side filled by the host interface; read side on lbus_rd/lbus_re.
- Supplies real full / almost-full / empty / almost-empty flags, so lbus_aful and lbus_aemp no longer need to be tied high.

Parameters:
- DEPTH_LOG2, 4: log2 of storage depth (DEPTH = 2**DEPTH_LOG2 = 16 bytes). Legal range 2..10.
- AFUL_TH, 2: AFUL asserts when free slots <= AFUL_TH. Legal range 1..DEPTH-1.
- AEMP_TH, 2: AEMP asserts when occupancy <= AEMP_TH. Legal range 1..DEPTH-1.

Ports:
- CLK  in  1  system clock (IBUFG output, 48 MHz)
- RSTn  in  1  reset
- WE  in  1  write enable, one byte per cycle
- DIN  in  8  write data
- FUL  out  1  1 = full; write is rejected
- AFUL  out  1  1 = near full
- RE  in  1  read enable, one byte per cycle
- DOUT  out  8  read data, registered
- EMP  out  1  1 = empty; read is rejected
- AEMP  out  1  1 = near empty
- COUNT  out  DEPTH_LOG2+1  current occupancy 0..DEPTH

Interface rule: One clock (CLK); reset RSTn is synchronous and active-low.

Behaviour:
- Reset:
  - Applies only on a CLK edge with RSTn=0.
  - Pointers=0, COUNT=0, EMP=1, AEMP=1, FUL=0, AFUL=0, DOUT=8'h00.
  - Storage array contents are not reset.
  - Reset mid-transfer discards all contents; no partial byte survives.
- Write acceptance:
  - Write accepted iff WE=1 and FUL=0, sampled at the edge.
  - On accept: mem[wptr] <= DIN; wptr increments modulo DEPTH (natural wrap, no extra pointer bit).
- Read acceptance:
  - Read accepted iff RE=1 and EMP=0.
  - On accept: DOUT <= mem[rptr] at that same edge, so data is valid the cycle after RE (latency 1); rptr increments modulo DEPTH.
  - DOUT holds its last value when no read is accepted.
- Simultaneous WE and RE:
  - Both accepted when 0 < COUNT < DEPTH; COUNT unchanged.
  - When full: only the read is accepted; the write is dropped, and COUNT goes DEPTH -> DEPTH-1.
  - When empty: only the write is accepted; the read is dropped, and DOUT is unchanged.
  - A byte is never readable in the same cycle it is written; no bypass.
- COUNT: next = COUNT + wr_acc - rd_acc, width DEPTH_LOG2+1; never exceeds DEPTH and never underflows.
- Flags:
  - Registered; computed from the next COUNT, so they change on the same edge as COUNT.
  - FUL = (COUNT==DEPTH); AFUL = (COUNT >= DEPTH-AFUL_TH); EMP = (COUNT==0); AEMP = (COUNT <= AEMP_TH).
- Rejected accesses have no side effects beyond the optional error flags.
- Control state: the FIFO has no multi-state FSM. Its state is (wptr, rptr, COUNT); the flag registers form the status state.

Optional Feature:
- Macro: LBUS_FIFO_ERR_STICKY_EN.
- When defined, adds two outputs: OVF (out 1) and UDF (out 1).
  - OVF sets on the edge after WE=1 with FUL=1.
  - UDF sets on the edge after RE=1 with EMP=1.
  - Both are sticky until reset, and are routed to spare LEDs for debug.
- When undefined, the ports and logic are absent and rejected accesses are silently dropped.

Decomposition:
- Package lbus_pkg (shared with the host interface): LBUS_DW=8, default depth and threshold constants, and a flag bit-index enum {FUL, AFUL, EMP, AEMP}.
- One sub-module, lbus_fifo_ram: DEPTH x 8 simple dual-port array with synchronous write and synchronous read-enable output, mapping to distributed RAM on the xc6slx75.
- Pointers, COUNT and flags stay in lbus_byte_fifo.

Test Plan:
- Reset check: hold RSTn=0 for 3 edges while WE=1, DIN=8'hA5 -> COUNT=0, EMP=1, AEMP=1, FUL=0, AFUL=0, DOUT=00; no write occurs.
- Fill and drain:
  - Write 8'h00..8'h0F on 16 consecutive cycles -> AFUL rises after the 14th write, FUL after the 16th; COUNT=16.
  - 17th write of 8'hFF is dropped (OVF=1 if enabled).
  - Read 16 bytes -> DOUT = 00..0F, each one cycle after its RE.
  - EMP=1 after the 16th read; AEMP rises when COUNT reaches 2.
- Wrap-around: write 10 bytes, read 10, then write 12 bytes 8'h20..8'h2B and read 12 -> data is in order across the pointer wrap; COUNT returns to 0.
- Simultaneous at full: FIFO full, WE=1 DIN=8'h77 and RE=1 -> one byte read out, 8'h77 dropped, COUNT=15, FUL falls.
- Simultaneous at empty: FIFO empty, WE=1 DIN=8'h3C and RE=1 -> DOUT unchanged, COUNT=1, EMP falls (UDF=1 if enabled); the next RE gives DOUT=3C.
- Reset mid-operation: 5 bytes queued, pulse RSTn=0 for one edge -> COUNT=0, EMP=1; a subsequent write/read of 8'h5A returns 5A, not stale data.
